// File: rtl/tts_pkg.sv
// -----------------------------------------------------------------------------
// tts_pkg
// Shared types and constants for the truth_table_sweeper block.
//   tts_state_t     : sweep FSM states (IDLE, DRIVE, SAMPLE, DONE)
//   TTS_EXPECT_31A  : default expected truth table, F = A(B+CD) + BC'
//   TTS_VEC_CNT_DEF : number of vectors swept for the default 4-input DUT
//   tts_vec_cnt()   : number of vectors swept for an n-input DUT (2**n)
// -----------------------------------------------------------------------------
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tts_state_t;

  localparam logic [15:0] TTS_EXPECT_31A  = 16'hF830;
  localparam int          TTS_N_IN_DEF    = 4;
  localparam int          TTS_VEC_CNT_DEF = 2 ** TTS_N_IN_DEF;

  function automatic int tts_vec_cnt(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
// Groups the sweeper's control, stimulus and result signals.
//   master : the sweeper (drives stim and all results, receives start/dut_f)
//   slave  : the board/bench side (drives start and dut_f)
// Optional macro TTS_FAIL_MAP_EN adds the per-vector fail_map signal.
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if #(
  parameter int N_IN = 4
);
  logic                 start;
  logic [N_IN-1:0]      stim;
  logic                 dut_f;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N_IN:0]        err_cnt;
  logic [N_IN-1:0]      first_fail;
  logic                 fail_valid;
`ifdef TTS_FAIL_MAP_EN
  logic [2**N_IN-1:0]   fail_map;

  modport master (
    input  start, dut_f,
    output stim, busy, done, pass, err_cnt, first_fail, fail_valid, fail_map
  );
  modport slave (
    output start, dut_f,
    input  stim, busy, done, pass, err_cnt, first_fail, fail_valid, fail_map
  );
`else
  modport master (
    input  start, dut_f,
    output stim, busy, done, pass, err_cnt, first_fail, fail_valid
  );
  modport slave (
    output start, dut_f,
    input  stim, busy, done, pass, err_cnt, first_fail, fail_valid
  );
`endif
endinterface

// File: rtl/tts_settle_timer.sv
// -----------------------------------------------------------------------------
// tts_settle_timer
// Counts 0..SETTLE-1 while enabled and pulses o_expire on the last count.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   i_load   : high outside the hold window; forces the count back to 0
//   o_expire : high in the last cycle of the hold window
// -----------------------------------------------------------------------------
module tts_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_expire
);

  localparam int            CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LASTC = CW'(SETTLE - 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = !i_load && (r_cnt == LASTC);

  always_ff @(posedge clk) begin
    if (rst || i_load || o_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Drives every input vector {A,B,C,D} to a combinational DUT, samples F after
// SETTLE hold cycles and compares it against the EXPECT truth table.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (overrides everything, even mid-sweep)
//   bus  : truth_table_sweeper_if.master
//          start (in), dut_f (in), stim, busy, done, pass, err_cnt,
//          first_fail, fail_valid (out)
// Optional macro TTS_FAIL_MAP_EN: adds bus.fail_map, one bit per vector that
// mismatched in the last sweep.
// -----------------------------------------------------------------------------
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int                 N_IN   = 4,
  parameter logic [2**N_IN-1:0] EXPECT = TTS_EXPECT_31A,
  parameter int                 SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.master bus
);

  localparam int              NV     = tts_vec_cnt(N_IN);
  localparam logic [N_IN-1:0] LASTIX = N_IN'(NV - 1);

  tts_state_t      r_state;
  tts_state_t      w_state_nxt;
  logic            w_expire;
  logic            w_timer_load;
  logic            w_mis;
  logic [N_IN:0]   w_err_nxt;
  logic [N_IN-1:0] r_stim;
  logic [N_IN-1:0] r_first_fail;
  logic [N_IN:0]   r_err_cnt;
  logic            r_pass;
  logic            r_fail_valid;
`ifdef TTS_FAIL_MAP_EN
  logic [NV-1:0]   r_fail_map;
`endif

  assign w_timer_load = (r_state != DRIVE);

  tts_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_timer_load),
    .o_expire (w_expire)
  );

  assign w_mis     = (r_state == SAMPLE) && (bus.dut_f != EXPECT[r_stim]);
  assign w_err_nxt = r_err_cnt + {{N_IN{1'b0}}, w_mis};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = DRIVE;
      DRIVE:   if (w_expire)  w_state_nxt = SAMPLE;
      SAMPLE:  w_state_nxt = (r_stim == LASTIX) ? DONE : DRIVE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stim       <= '0;
      r_err_cnt    <= '0;
      r_first_fail <= '0;
      r_fail_valid <= 1'b0;
      r_pass       <= 1'b0;
`ifdef TTS_FAIL_MAP_EN
      r_fail_map   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_stim       <= '0;
            r_err_cnt    <= '0;
            r_first_fail <= '0;
            r_fail_valid <= 1'b0;
            r_pass       <= 1'b0;
`ifdef TTS_FAIL_MAP_EN
            r_fail_map   <= '0;
`endif
          end
        end
        SAMPLE: begin
          r_err_cnt <= w_err_nxt;
          if (w_mis && !r_fail_valid) begin
            r_first_fail <= r_stim;
            r_fail_valid <= 1'b1;
          end
`ifdef TTS_FAIL_MAP_EN
          if (w_mis) r_fail_map[r_stim] <= 1'b1;
`endif
          // pass uses the updated count so it is already valid during DONE
          if (r_stim == LASTIX) begin
            r_pass <= (w_err_nxt == '0);
          end else begin
            r_stim <= r_stim + N_IN'(1);
          end
        end
        DONE:    r_stim <= '0;
        default: ;
      endcase
    end
  end

  assign bus.stim       = r_stim;
  assign bus.busy       = (r_state == DRIVE) || (r_state == SAMPLE);
  assign bus.done       = (r_state == DONE);
  assign bus.pass       = r_pass;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.first_fail = r_first_fail;
  assign bus.fail_valid = r_fail_valid;
`ifdef TTS_FAIL_MAP_EN
  assign bus.fail_map   = r_fail_map;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Bench for truth_table_sweeper: one instance with SETTLE=1, one with SETTLE=3.
// The DUT side is modelled as a 16-entry response table indexed by stim.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;
  import tts_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(4)) bus1 ();
  truth_table_sweeper_if #(.N_IN(4)) bus3 ();

  logic [15:0] pat1;
  logic [15:0] pat3;
  assign bus1.dut_f = pat1[bus1.stim];
  assign bus3.dut_f = pat3[bus3.stim];

  truth_table_sweeper #(.N_IN(4), .EXPECT(16'hF830), .SETTLE(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );
  truth_table_sweeper #(.N_IN(4), .EXPECT(16'hF830), .SETTLE(3)) dut3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference: the lab function written straight from its boolean equation.
  function automatic bit f_ref(input int idx);
    bit a, b, c, d;
    a = idx[3]; b = idx[2]; c = idx[1]; d = idx[0];
    return (a & (b | (c & d))) | (b & ~c);
  endfunction

  function automatic void ref_sweep(input logic [15:0] resp, output int e, output int ff,
                                    output int fv, output int ps, output int map);
    e = 0; ff = 0; map = 0;
    for (int i = 0; i < 16; i++) begin
      if (resp[i] != f_ref(i)) begin
        if (e == 0) ff = i;
        e++;
        map = map | (1 << i);
      end
    end
    fv = (e > 0) ? 1 : 0;
    ps = (e == 0) ? 1 : 0;
  endfunction

  // Runs one sweep on dut1; returns at the negedge where done is seen.
  task automatic sweep1(input logic [15:0] resp, input bit poke, output int bcyc,
                        output int got, output int r_err, output int r_ff,
                        output int r_fv, output int r_ps, output int r_map);
    pat1 = resp;
    bcyc = 0; got = 0; r_err = -1; r_ff = -1; r_fv = -1; r_ps = -1; r_map = -1;
    @(negedge clk); bus1.start = 1'b1;
    @(negedge clk); bus1.start = 1'b0;
    for (int k = 0; k < 200 && got == 0; k++) begin
      if (bus1.busy) bcyc++;
      if (bus1.done) begin
        got   = 1;
        r_err = int'(bus1.err_cnt);
        r_ff  = int'(bus1.first_fail);
        r_fv  = int'(bus1.fail_valid);
        r_ps  = int'(bus1.pass);
`ifdef TTS_FAIL_MAP_EN
        r_map = int'(bus1.fail_map);
`else
        r_map = 0;
`endif
      end else begin
        bus1.start = poke && (k % 7 == 3);
        @(negedge clk);
      end
    end
    bus1.start = 1'b0;
  endtask

  typedef struct {
    logic [15:0] resp;
    int          e_err;
    int          e_ff;
    int          e_fv;
    int          e_ps;
    int          e_map;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int bcyc, got, g_err, g_ff, g_fv, g_ps, g_map;
    int m_err, m_ff, m_fv, m_ps, m_map;
    int done_seen, stim_bad, pre_err;
    logic [15:0] rp;

    tbl[0] = '{16'hF830, 0, 0,  0, 1, 32'h0000};
    tbl[1] = '{16'h0000, 7, 4,  1, 0, 32'hF830};
    tbl[2] = '{16'hFFFF, 9, 0,  1, 0, 32'h07CF};
    tbl[3] = '{16'hF030, 1, 11, 1, 0, 32'h0800};
    tbl[4] = '{16'hF830, 0, 0,  0, 1, 32'h0000};

    rst = 1'b1; bus1.start = 1'b0; bus3.start = 1'b0; pat1 = 16'hF830; pat3 = 16'hF830;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy",  int'(bus1.busy), 0);
    chk("rst_done",  int'(bus1.done), 0);
    chk("rst_pass",  int'(bus1.pass), 0);
    chk("rst_err",   int'(bus1.err_cnt), 0);
    chk("rst_ff",    int'(bus1.first_fail), 0);
    chk("rst_fv",    int'(bus1.fail_valid), 0);
    chk("rst_stim",  int'(bus1.stim), 0);
    chk("rst3_busy", int'(bus3.busy), 0);

    // Table-driven sweeps (last entry re-runs ideal after the index-11 fault).
    for (int t = 0; t < 5; t++) begin
      sweep1(tbl[t].resp, 1'b0, bcyc, got, g_err, g_ff, g_fv, g_ps, g_map);
      chk($sformatf("tbl%0d_done", t),  got, 1);
      chk($sformatf("tbl%0d_busy", t),  bcyc, 32);
      chk($sformatf("tbl%0d_err", t),   g_err, tbl[t].e_err);
      chk($sformatf("tbl%0d_ff", t),    g_ff, tbl[t].e_ff);
      chk($sformatf("tbl%0d_fv", t),    g_fv, tbl[t].e_fv);
      chk($sformatf("tbl%0d_pass", t),  g_ps, tbl[t].e_ps);
`ifdef TTS_FAIL_MAP_EN
      chk($sformatf("tbl%0d_map", t),   g_map, tbl[t].e_map);
`endif
      @(negedge clk);
      chk($sformatf("tbl%0d_donepulse", t), int'(bus1.done), 0);
      repeat (3) @(negedge clk);
      chk($sformatf("tbl%0d_hold_err", t),  int'(bus1.err_cnt), tbl[t].e_err);
      chk($sformatf("tbl%0d_hold_pass", t), int'(bus1.pass), tbl[t].e_ps);
      chk($sformatf("tbl%0d_stim_idle", t), int'(bus1.stim), 0);
    end

    // start re-pulsed while busy, then held through DONE: both ignored.
    sweep1(16'hF030, 1'b1, bcyc, got, g_err, g_ff, g_fv, g_ps, g_map);
    chk("poke_done", got, 1);
    chk("poke_busy", bcyc, 32);
    chk("poke_err",  g_err, 1);
    bus1.start = 1'b1;
    @(negedge clk); bus1.start = 1'b0;
    chk("poke_in_done_busy", int'(bus1.busy), 0);
    @(negedge clk);
    chk("poke_in_done_busy2", int'(bus1.busy), 0);
    chk("poke_in_done_err",   int'(bus1.err_cnt), 1);

    // Reset on busy cycle 10 of a stuck-at-1 sweep.
    pat1 = 16'hFFFF;
    pre_err = 0;
    for (int i = 0; i < 4; i++) if (pat1[i] != f_ref(i)) pre_err++;
    @(negedge clk); bus1.start = 1'b1;
    @(negedge clk); bus1.start = 1'b0;
    bcyc = 0;
    for (int k = 0; k < 50 && bcyc < 10; k++) begin
      if (bus1.busy) bcyc++;
      if (bcyc < 10) @(negedge clk);
    end
    chk("mid_reached", bcyc, 10);
    chk("mid_err_before", int'(bus1.err_cnt), pre_err);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", int'(bus1.busy), 0);
    chk("mid_rst_stim", int'(bus1.stim), 0);
    chk("mid_rst_err",  int'(bus1.err_cnt), 0);
    chk("mid_rst_fv",   int'(bus1.fail_valid), 0);
    chk("mid_rst_done", int'(bus1.done), 0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus1.done || bus1.busy) done_seen++;
    end
    chk("mid_no_done", done_seen, 0);

    // Randomized responses against the equation-based reference.
    for (int r = 0; r < 20; r++) begin
      if (r % 2 == 0) rp = 16'($urandom);
      else            rp = 16'hF830 ^ (16'h1 << $urandom_range(0, 15));
      ref_sweep(rp, m_err, m_ff, m_fv, m_ps, m_map);
      sweep1(rp, 1'b0, bcyc, got, g_err, g_ff, g_fv, g_ps, g_map);
      chk($sformatf("rnd%0d_busy", r), bcyc, 32);
      chk($sformatf("rnd%0d_err", r),  g_err, m_err);
      chk($sformatf("rnd%0d_ff", r),   g_ff, m_ff);
      chk($sformatf("rnd%0d_fv", r),   g_fv, m_fv);
      chk($sformatf("rnd%0d_pass", r), g_ps, m_ps);
`ifdef TTS_FAIL_MAP_EN
      chk($sformatf("rnd%0d_map", r),  g_map, m_map);
`endif
      @(negedge clk);
    end

    // SETTLE=3: each vector held 4 busy cycles, 64 busy cycles total.
    pat3 = 16'hF830;
    @(negedge clk); bus3.start = 1'b1;
    @(negedge clk); bus3.start = 1'b0;
    bcyc = 0; got = 0; stim_bad = 0;
    for (int k = 0; k < 300 && got == 0; k++) begin
      if (bus3.busy) begin
        if (int'(bus3.stim) != bcyc / 4) stim_bad++;
        bcyc++;
      end
      if (bus3.done) got = 1;
      else @(negedge clk);
    end
    chk("s3_done", got, 1);
    chk("s3_busy", bcyc, 64);
    chk("s3_stim_hold", stim_bad, 0);
    chk("s3_pass", int'(bus3.pass), 1);
    chk("s3_err",  int'(bus3.err_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
